// File: rtl/onehot_decode_fifo_if.sv
// Handshake bundle between an encoded-index source, the decode FIFO and a one-hot consumer.
// Latency: none; this file only groups wires.
// Backpressure: in_ready flows back to the source and out_ready flows in from the consumer.
interface onehot_decode_fifo_if #(
   parameter int N_CODE = 2
);
   logic                   in_valid;
   logic                   in_ready;
   logic [N_CODE-1:0]      in_code;
   logic                   in_none;
   logic                   out_valid;
   logic                   out_ready;
   logic [(2**N_CODE)-1:0] out_onehot;
   logic                   out_none;

   // Environment side: drives source inputs and consumer ready.
   modport master (
      output in_valid, in_code, in_none, out_ready,
      input  in_ready, out_valid, out_onehot, out_none
   );

   // FIFO side.
   modport slave (
      input  in_valid, in_code, in_none, out_ready,
      output in_ready, out_valid, out_onehot, out_none
   );
endinterface

// File: rtl/onehot_decode_fifo.sv
// Buffers encoded line indices and presents the head entry as a one-hot line vector.
// Latency: 1 cycle from push to visibility (no bypass).
// Backpressure: in_ready = not full, registered-only; a full FIFO refuses a push even during a pop.
module onehot_decode_fifo #(
   parameter int N_CODE = 2,
   parameter int DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   onehot_decode_fifo_if.slave    bus,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int OW = 2**N_CODE;

   // Each entry is {none, code}.
   logic [N_CODE:0]   mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic              push, pop;
   logic [N_CODE:0]   head;
   logic [OW-1:0]     onehot_d;

   // Handshake qualifiers; both ready/valid come from registered level only.
   assign bus.in_ready  = (level_q != LW'(DEPTH));
   assign bus.out_valid = (level_q != '0);
   assign push          = bus.in_valid && bus.in_ready;
   assign pop           = bus.out_valid && bus.out_ready;
   assign head          = mem_q[rd_ptr_q];
   assign level         = level_q;

   // Next-state for pointers and occupancy; level alone encodes EMPTY/PARTIAL/FULL.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // Control state register with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Entry storage; contents after reset are don't-care, so no reset here.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {bus.in_none, bus.in_code};
   end

   // Decode the head entry; everything reads zero while empty.
   always_comb begin
      onehot_d = '0;
      if (bus.out_valid && !head[N_CODE]) onehot_d[head[N_CODE-1:0]] = 1'b1;
   end

   assign bus.out_onehot = onehot_d;
   assign bus.out_none   = bus.out_valid && head[N_CODE];
endmodule

// File: tb/tb_onehot_decode_fifo.sv
// Directed bench for onehot_decode_fifo with a small queue scoreboard for the wrap stream.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// All comparisons go through check().
module tb_onehot_decode_fifo;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] level;
   int         n_checks = 0;
   int         n_fail   = 0;

   onehot_decode_fifo_if #(.N_CODE(2)) ifc ();

   onehot_decode_fifo #(.N_CODE(2), .DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc),
      .level (level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push1(input logic [1:0] code, input logic none);
      ifc.in_valid = 1'b1;
      ifc.in_code  = code;
      ifc.in_none  = none;
      step();
      ifc.in_valid = 1'b0;
   endtask

   function automatic logic [4:0] model_decode(input logic [2:0] e);
      logic [3:0] oh;
      oh = 4'b0000;
      if (!e[2]) oh[e[1:0]] = 1'b1;
      return {e[2], oh};
   endfunction

   logic [2:0] model_q [$];
   logic [2:0] exp_e;
   logic [4:0] held;
   logic [1:0] pat [4];
   logic       do_push, do_pop, stall;
   int         sent, popped;

   initial begin
      pat = '{2'd3, 2'd1, 2'd0, 2'd2};
      ifc.in_valid  = 1'b0;
      ifc.in_code   = 2'd0;
      ifc.in_none   = 1'b0;
      ifc.out_ready = 1'b0;

      // Reset values
      #1;
      check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
      check("rst_level",     32'(level),         32'd0);
      check("rst_in_ready",  32'(ifc.in_ready),  32'd1);
      check("rst_onehot",    32'(ifc.out_onehot), 32'd0);
      check("rst_none",      32'(ifc.out_none),  32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // Mid-stream reset with 3 entries buffered
      push1(2'd1, 1'b0);
      push1(2'd2, 1'b0);
      push1(2'd3, 1'b0);
      check("pre_rst_level", 32'(level), 32'd3);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(ifc.out_valid), 32'd0);
      check("mid_rst_level",     32'(level),         32'd0);
      check("mid_rst_in_ready",  32'(ifc.in_ready),  32'd1);
      #2;
      rst_n = 1'b1;
      push1(2'd2, 1'b0);
      check("post_rst_onehot", 32'(ifc.out_onehot), 32'h4);
      check("post_rst_valid",  32'(ifc.out_valid),  32'd1);
      ifc.out_ready = 1'b1;
      step();
      check("post_rst_drain", 32'(level), 32'd0);

      // Decode sweep, out_ready held high: each entry visible one cycle after push
      begin
         logic [1:0] codes [5];
         logic       nones [5];
         logic [3:0] exp_oh [5];
         codes  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
         nones  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
         exp_oh = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
         for (int i = 0; i < 5; i++) begin
            ifc.in_valid = 1'b1;
            ifc.in_code  = codes[i];
            ifc.in_none  = nones[i];
            step();
            check("sweep_onehot", 32'(ifc.out_onehot), 32'(exp_oh[i]));
            check("sweep_none",   32'(ifc.out_none),   32'(nones[i]));
         end
         ifc.in_valid = 1'b0;
         ifc.in_none  = 1'b0;
         step();
         check("sweep_empty", 32'(level), 32'd0);
      end

      // Fill and backpressure
      ifc.out_ready = 1'b0;
      push1(2'd3, 1'b0);
      push1(2'd0, 1'b0);
      push1(2'd1, 1'b0);
      push1(2'd2, 1'b0);
      check("full_level",    32'(level),          32'd4);
      check("full_in_ready", 32'(ifc.in_ready),   32'd0);
      check("full_head",     32'(ifc.out_onehot), 32'h8);
      ifc.in_valid = 1'b1;
      ifc.in_code  = 2'd1;
      step();
      step();
      check("refused_level", 32'(level), 32'd4);
      ifc.out_ready = 1'b1;
      step();
      check("refused_on_pop_level", 32'(level),          32'd3);
      check("refused_on_pop_head",  32'(ifc.out_onehot), 32'h1);
      ifc.out_ready = 1'b0;
      step();
      check("accepted_level", 32'(level), 32'd4);
      ifc.in_valid  = 1'b0;
      ifc.out_ready = 1'b1;
      step();
      check("drain_head1", 32'(ifc.out_onehot), 32'h2);
      step();
      check("drain_head2", 32'(ifc.out_onehot), 32'h4);
      step();
      check("drain_head3", 32'(ifc.out_onehot), 32'h2);
      step();
      check("drain_level", 32'(level), 32'd0);

      // Simultaneous push+pop at level 2; entry j carries code j%4
      ifc.out_ready = 1'b0;
      push1(2'd0, 1'b0);
      push1(2'd1, 1'b0);
      check("pp_start_level", 32'(level), 32'd2);
      ifc.out_ready = 1'b1;
      ifc.in_valid  = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         ifc.in_code = 2'((k + 1) % 4);
         step();
         check("pp_level",  32'(level),          32'd2);
         check("pp_onehot", 32'(ifc.out_onehot), 32'(1 << (k % 4)));
      end
      ifc.in_valid = 1'b0;
      step();
      step();
      check("pp_drained", 32'(level), 32'd0);

      // Wrap-around stream with random consumer stalls
      sent   = 0;
      popped = 0;
      for (int cyc = 0; cyc < 400 && popped < 11; cyc++) begin
         if (sent < 11) begin
            ifc.in_valid = 1'b1;
            ifc.in_code  = pat[sent % 4];
            ifc.in_none  = (sent == 6);
         end else begin
            ifc.in_valid = 1'b0;
            ifc.in_none  = 1'b0;
         end
         ifc.out_ready = ($urandom_range(0, 2) != 0);
         #1;
         do_push = ifc.in_valid && ifc.in_ready;
         do_pop  = ifc.out_valid && ifc.out_ready;
         stall   = ifc.out_valid && !ifc.out_ready;
         held    = {ifc.out_none, ifc.out_onehot};
         if (do_pop) begin
            if (model_q.size() == 0) begin
               check("wrap_unexpected_pop", 32'd1, 32'd0);
            end else begin
               exp_e = model_q.pop_front();
               check("wrap_data", 32'({ifc.out_none, ifc.out_onehot}), 32'(model_decode(exp_e)));
            end
            popped++;
         end
         if (do_push) begin
            model_q.push_back({ifc.in_none, ifc.in_code});
            sent++;
         end
         @(posedge clk);
         #1;
         if (stall) check("wrap_stall_hold", 32'({ifc.out_none, ifc.out_onehot}), 32'(held));
      end
      check("wrap_count", 32'(popped), 32'd11);
      ifc.in_valid  = 1'b0;
      ifc.in_none   = 1'b0;
      ifc.out_ready = 1'b0;
      step();

      // Empty behaviour: ready toggling must not move pointers
      check("empty_valid",  32'(ifc.out_valid),  32'd0);
      check("empty_onehot", 32'(ifc.out_onehot), 32'd0);
      check("empty_none",   32'(ifc.out_none),   32'd0);
      for (int t = 0; t < 4; t++) begin
         ifc.out_ready = t[0];
         step();
      end
      check("empty_toggle_level", 32'(level), 32'd0);
      ifc.out_ready = 1'b0;
      push1(2'd3, 1'b0);
      check("empty_then_push", 32'(ifc.out_onehot), 32'h8);
      check("empty_then_level", 32'(level), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/onehot_decode_fifo.md
Name: onehot_decode_fifo

Overview:
- Decode-side counterpart of the team's 4-input priority encoder.
- Accepts encoded line indices (2-bit code plus an explicit "no line active" flag) over a valid/ready handshake.
- Buffers them in a small FIFO and presents each as a one-hot line vector on a valid/ready output.
- Sits between an encoder-fed event source and a consumer that needs one-hot line strobes.

Parameters:
- N_CODE, 2, width of the encoded index; output width is 2**N_CODE.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  source presents an entry.
- in_ready  output  1  block can accept an entry this cycle.
- in_code  input  N_CODE  encoded line index.
- in_none  input  1  1 = no line was active; decodes to all-zero vector, and in_code is ignored.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer takes head entry this cycle.
- out_onehot  output  2**N_CODE  decoded head entry.
- out_none  output  1  head entry was a "none" entry.
- level  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- **Reset** (rst_n low, asynchronous):
  - Clears wr_ptr, rd_ptr and level.
  - Outputs: out_valid=0, out_onehot=0, out_none=0, level=0, in_ready=1.
  - Storage contents are don't-care.
  - Reset mid-operation discards all buffered entries. The first entry accepted after release is the first one presented.
- **Push**: occurs when in_valid && in_ready at a rising edge.
  - Stores {in_none, in_code} at wr_ptr; wr_ptr increments mod DEPTH.
- **Pop**: occurs when out_valid && out_ready at a rising edge; rd_ptr increments mod DEPTH.
- **in_ready** = (level != DEPTH). It depends only on registered state, with no combinational path from out_ready. When full, a push is refused even if a pop happens in the same cycle.
- **out_valid** = (level != 0). No bypass: an entry pushed at edge k is visible from the cycle after edge k, so minimum latency is 1 cycle.
- **out_onehot** (decoded combinationally from the head entry):
  - If out_valid && !head.none: bit[head.code]=1, all other bits 0.
  - If out_valid && head.none: all zero, with out_none=1.
  - If !out_valid: out_onehot=0 and out_none=0.
- **level update**:
  - Push only: +1.
  - Pop only: -1.
  - Both or neither: unchanged.
  - Never exceeds DEPTH and never underflows, because the handshake rules forbid it.
- **Source-side rule**: in_valid/in_code/in_none may change freely while in_ready=0. No source-side stability is assumed by the block.
- **Consumer-side guarantee**: while out_valid=1 and out_ready=0, out_onehot and out_none hold stable.
- **Pointer wrap**: binary pointers of width clog2(DEPTH) wrap naturally. Full and empty are distinguished by level only.
- **Ordering**: strict FIFO order is maintained across wrap-around.
- **Implementation form**: the state machine is implicit in level. Named states are EMPTY (level=0), PARTIAL, and FULL (level=DEPTH). Transitions follow the level rules above.

Test Plan:
- **Reset**: reset asserted mid-stream with 3 entries buffered -> out_valid=0, level=0, in_ready=1 immediately. After release, push code 2 -> next cycle out_onehot=0100, out_valid=1.
- **Full decode sweep**: push codes 0,1,2,3 and one none entry with out_ready=1 -> outputs 0001, 0010, 0100, 1000, 0000 (out_none=1), in order, each 1 cycle after its push.
- **Fill/backpressure**: out_ready=0, push 4 entries -> level=4, in_ready=0.
  - A 5th in_valid held for 3 cycles is not accepted, even in the cycle out_ready is raised.
  - It is accepted on the following cycle.
- **Simultaneous push+pop** at level=2 for 10 cycles -> level stays 2, data order preserved.
- **Wrap-around**: stream 11 entries with code pattern 3,1,0,2,... and random out_ready stalls -> output sequence matches input sequence exactly, and out_onehot stays stable during stalls.
- **Empty**: drain to level=0 -> out_valid=0, out_onehot=0000, out_none=0. Toggling out_ready has no effect on pointers.
